wb_regfile: RTL

- Architectural register file: the consumer at the write-back end of the MEM-to-WB pipeline path, and the supplier of operands to the decode stage.
- 32 x WORD_LEN registers, one write port driven by the WB result, two combinational read ports for ID.
- Includes write-to-read bypass.
- Includes a per-register pending-write scoreboard so ID can detect load-use hazards and stall.

---
 rtl/wb_regfile_pkg.sv | 11 +
 rtl/wb_scoreboard.sv | 56 +++++
 rtl/wb_regfile.sv | 74 +++++++
 3 files changed

// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared pipeline constants for the register file path
// Purpose: word and register-address widths shared by the ID/EX/WB pipeline
//          registers, the register file and its pending-write scoreboard.
// Ports:   none (package).
package wb_regfile_pkg;

  localparam int WORD_LEN     = 32;
  localparam int REG_ADDR_LEN = 5;
  localparam int NUM_REGS     = 32;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register pending-write bits with busy generation
// Purpose: tracks registers whose producing instruction (a load) has issued
//          but not yet written back, so ID can stall on load-use hazards.
// Ports:   clk, nReset        - clock, synchronous active-low reset
//          issue_en/addr      - marks a destination pending from next cycle
//          flush              - clears every pending bit
//          wr_en/wr_addr      - WB write, clears the destination's bit
//          rs1_addr/rs2_addr  - ID source addresses
//          busy_rs1/busy_rs2  - source still waiting on an outstanding write
import wb_regfile_pkg::*;

module wb_scoreboard #(
  parameter int NUM_R = NUM_REGS
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    issue_en,
  input  logic [REG_ADDR_LEN-1:0] issue_addr,
  input  logic                    flush,
  input  logic                    wr_en,
  input  logic [REG_ADDR_LEN-1:0] wr_addr,
  input  logic [REG_ADDR_LEN-1:0] rs1_addr,
  input  logic [REG_ADDR_LEN-1:0] rs2_addr,
  output logic                    busy_rs1,
  output logic                    busy_rs2
);

  logic [NUM_R-1:0] pending_q;
  logic [NUM_R-1:0] pending_d;

  // Clear is applied before set so that a same-cycle issue to the register
  // being written back keeps it pending: the newer load owns the result.
  always_comb begin
    pending_d = pending_q;
    if (flush) begin
      pending_d = '0;
    end else begin
      if (wr_en) pending_d[wr_addr] = 1'b0;
      if (issue_en) pending_d[issue_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nReset) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  // A write-back in the same cycle resolves the hazard because the register
  // file bypasses Wr_Data straight to the read port.
  always_comb begin
    busy_rs1 = (rs1_addr != '0) && pending_q[rs1_addr] && !(wr_en && (wr_addr == rs1_addr));
    busy_rs2 = (rs2_addr != '0) && pending_q[rs2_addr] && !(wr_en && (wr_addr == rs2_addr));
  end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - architectural register file with WB bypass and scoreboard
// Purpose: 32 x DATA_W registers written by WB, two combinational read ports
//          for ID with write-first bypass, plus load-use busy flags.
// Ports:   clk, nReset              - clock, synchronous active-low reset
//          Reg_W_En/Wr_Addr/Wr_Data - WB write port (x0 writes ignored)
//          Rs1_Addr/Rs2_Addr        - ID read addresses
//          Rs1_Data/Rs2_Data        - combinational operands
//          Issue_En/Issue_Addr      - ID issues a late-result instruction
//          Flush                    - pipeline flush, clears pending bits
//          Busy_Rs1/Busy_Rs2        - source has an outstanding pending write
import wb_regfile_pkg::*;

module wb_regfile #(
  parameter int NUM_REGS = wb_regfile_pkg::NUM_REGS,
  parameter int DATA_W   = WORD_LEN
) (
  input  logic                    clk,
  input  logic                    nReset,
  input  logic                    Reg_W_En,
  input  logic [REG_ADDR_LEN-1:0] Wr_Addr,
  input  logic [DATA_W-1:0]       Wr_Data,
  input  logic [REG_ADDR_LEN-1:0] Rs1_Addr,
  input  logic [REG_ADDR_LEN-1:0] Rs2_Addr,
  output logic [DATA_W-1:0]       Rs1_Data,
  output logic [DATA_W-1:0]       Rs2_Data,
  input  logic                    Issue_En,
  input  logic [REG_ADDR_LEN-1:0] Issue_Addr,
  input  logic                    Flush,
  output logic                    Busy_Rs1,
  output logic                    Busy_Rs2
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];

  always_comb begin
    regs_d = regs_q;
    if (Reg_W_En && (Wr_Addr != '0)) regs_d[Wr_Addr] = Wr_Data;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!nReset) regs_q <= '{default: '0};
    else         regs_q <= regs_d;
  end

  // Write-first: a WB result landing this cycle is visible to ID immediately.
  always_comb begin
    Rs1_Data = regs_q[Rs1_Addr];
    if (Reg_W_En && (Wr_Addr == Rs1_Addr)) Rs1_Data = Wr_Data;
    if (Rs1_Addr == '0) Rs1_Data = '0;

    Rs2_Data = regs_q[Rs2_Addr];
    if (Reg_W_En && (Wr_Addr == Rs2_Addr)) Rs2_Data = Wr_Data;
    if (Rs2_Addr == '0) Rs2_Data = '0;
  end

  wb_scoreboard #(
    .NUM_R(NUM_REGS)
  ) u_scoreboard (
    .clk        (clk),
    .nReset     (nReset),
    .issue_en   (Issue_En),
    .issue_addr (Issue_Addr),
    .flush      (Flush),
    .wr_en      (Reg_W_En),
    .wr_addr    (Wr_Addr),
    .rs1_addr   (Rs1_Addr),
    .rs2_addr   (Rs2_Addr),
    .busy_rs1   (Busy_Rs1),
    .busy_rs2   (Busy_Rs2)
  );

endmodule
